// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: stage payload widths, control-bit positions,
// the bubble control word and the main-entry load-source encoding.
package pipe_stage_skid_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CTRL_W_DEF = 6;

  // Per-stage data payload widths for the 16-bit processor.
  localparam int ID_EX_DATA_W  = 16 * 5 + 3;       // A, B, imm, nextPC, pc, writeregsel
  localparam int EX_MEM_DATA_W = 16 * 4 + 3 + 7;   // B, ALURes, nextPC, pc, AB, writeregsel
  localparam int MEM_WB_DATA_W = 16 * 3 + 3;       // memdata, ALURes, nextPC, writeregsel

  // Control-bit positions inside the control payload.
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_JAL        = 4;
  localparam int CTRL_HALT       = 5;

  // All side-effect bits low: a bubble can never write state downstream.
  localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE_DEF = '0;

  typedef enum logic [1:0] {
    SRC_HOLD,
    SRC_IN,
    SRC_SKID
  } main_src_e;

  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying a data and a control payload.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 6
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input  ready);
  modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

// File: rtl/register_n.sv
// Parametrised register with write enable and synchronous reset value;
// the building block for both pipeline-stage entries.
module register_n #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready flow control, optional two-entry
// skid buffer and synchronous flush that turns held instructions into bubbles.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                CTRL_W      = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEF),
  parameter bit                SKID        = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  pipe_stage_skid_if.slave         in_if,
  pipe_stage_skid_if.master        out_if,
  input  logic                     flush,
  output logic [1:0]               occupancy
);

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic              m_valid_d, s_valid_d, s_load;
  logic [DATA_W-1:0] m_data_d;
  logic [CTRL_W-1:0] m_ctrl_d, s_ctrl_d;
  logic              accept, drain;
  main_src_e         m_src;

  // With a skid entry in_ready depends only on local state, cutting the
  // out_ready -> in_ready path between stages.
  assign in_if.ready = (SKID ? ~s_valid : (~m_valid | out_if.ready)) & ~rst;
  assign accept      = in_if.valid & in_if.ready;
  assign drain       = m_valid & out_if.ready;

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    m_src     = SRC_HOLD;
    m_valid_d = m_valid;
    s_valid_d = s_valid;
    s_load    = 1'b0;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (drain && s_valid) begin
      m_src     = SRC_SKID;
      s_valid_d = 1'b0;
    end else if (accept && (!m_valid || drain)) begin
      m_src     = SRC_IN;
      m_valid_d = 1'b1;
    end else if (accept) begin
      s_load    = 1'b1;
      s_valid_d = 1'b1;
    end else if (drain) begin
      m_valid_d = 1'b0;
    end
  end

  always_comb begin
    m_data_d = m_data;
    m_ctrl_d = m_ctrl;
    unique case (m_src)
      SRC_IN:   begin m_data_d = in_if.data; m_ctrl_d = in_if.ctrl; end
      SRC_SKID: begin m_data_d = s_data;     m_ctrl_d = s_ctrl;     end
      default:  ;
    endcase
    if (flush) m_ctrl_d = CTRL_BUBBLE;
  end

  assign s_ctrl_d = flush ? CTRL_BUBBLE : in_if.ctrl;

  register_n #(.W(1)) u_m_valid (
    .clk(clk), .rst(rst), .en(1'b1), .d(m_valid_d), .q(m_valid)
  );
  register_n #(.W(DATA_W)) u_m_data (
    .clk(clk), .rst(rst), .en(m_src != SRC_HOLD), .d(m_data_d), .q(m_data)
  );
  register_n #(.W(CTRL_W), .RST_VAL(CTRL_BUBBLE)) u_m_ctrl (
    .clk(clk), .rst(rst), .en(flush || (m_src != SRC_HOLD)), .d(m_ctrl_d), .q(m_ctrl)
  );
  register_n #(.W(2)) u_occ (
    .clk(clk), .rst(rst), .en(1'b1), .d(occ_count(m_valid_d, s_valid_d)), .q(occupancy)
  );

  if (SKID) begin : g_skid
    register_n #(.W(1)) u_s_valid (
      .clk(clk), .rst(rst), .en(1'b1), .d(s_valid_d), .q(s_valid)
    );
    register_n #(.W(DATA_W)) u_s_data (
      .clk(clk), .rst(rst), .en(s_load), .d(in_if.data), .q(s_data)
    );
    register_n #(.W(CTRL_W), .RST_VAL(CTRL_BUBBLE)) u_s_ctrl (
      .clk(clk), .rst(rst), .en(flush || s_load), .d(s_ctrl_d), .q(s_ctrl)
    );
  end else begin : g_no_skid
    assign s_valid = 1'b0;
    assign s_data  = '0;
    assign s_ctrl  = CTRL_BUBBLE;
  end

  assign out_if.valid = m_valid;
  assign out_if.data  = m_data;
  assign out_if.ctrl  = m_valid ? m_ctrl : CTRL_BUBBLE;

endmodule
